// File: rtl/wb_cfg_initiator_if.sv
// Bundle of the command, response and Wishbone signals of wb_cfg_initiator.
// master = the initiator itself, slave = the control source plus the WB target.
//
// Handshake rules (cmd_* and rsp_*): a transfer happens on a rising clock edge
// where valid and ready are both 1. A producer raises valid only with stable
// payload and keeps valid and payload unchanged until that edge. ready may be
// raised or dropped at any time and never depends on valid.
interface wb_cfg_initiator_if #(
  parameter int ADR_W = 22,
  parameter int DAT_W = 32
);
  logic               cmd_valid_i;
  logic               cmd_ready_o;
  logic               cmd_we_i;
  logic [ADR_W-1:0]   cmd_adr_i;
  logic [DAT_W-1:0]   cmd_dat_i;

  logic               rsp_valid_o;
  logic               rsp_ready_i;
  logic [DAT_W-1:0]   rsp_dat_o;
  logic [1:0]         rsp_status_o;
  logic               rsp_mismatch_o;

  logic               wb_cyc_o;
  logic               wb_stb_o;
  logic               wb_we_o;
  logic [ADR_W-1:0]   wb_adr_o;
  logic [DAT_W-1:0]   wb_dat_o;
  logic [DAT_W/8-1:0] wb_sel_o;
  logic               wb_ack_i;
  logic               wb_err_i;
  logic               wb_rty_i;
  logic [DAT_W-1:0]   wb_dat_i;

  modport master (
    input  cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, rsp_ready_i,
           wb_ack_i, wb_err_i, wb_rty_i, wb_dat_i,
    output cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_status_o, rsp_mismatch_o,
           wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o
  );

  modport slave (
    output cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, rsp_ready_i,
           wb_ack_i, wb_err_i, wb_rty_i, wb_dat_i,
    input  cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_status_o, rsp_mismatch_o,
           wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o
  );
endinterface

// File: rtl/wb_cfg_initiator.sv
// Wishbone classic initiator for the trigger-chain configuration space.
// Commands are queued in a small FIFO and executed one at a time as single
// WB cycles; ack/err/rty and a no-response timeout each yield one response.
// Address layout on the target side: channel in adr[10:8], register in adr[7:0].
// Optional feature: define WB_CFG_READBACK_VERIFY_EN to follow every acked
// write with a read of the same address and flag a readback mismatch.
module wb_cfg_initiator #(
  parameter int ADR_W          = 22,
  parameter int DAT_W          = 32,
  parameter int CMD_DEPTH      = 4,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int MAX_RETRY      = 3
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_n_i,
  wb_cfg_initiator_if.master bus,
  output logic               busy_o,
  output logic [2:0]         dbg_state
);

  localparam int PTR_W = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
  localparam int CNT_W = $clog2(CMD_DEPTH + 1);
  localparam int TMO_W = ($clog2(TIMEOUT_CYCLES + 1) > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int RTY_W = ($clog2(MAX_RETRY + 1) > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int SEL_W = DAT_W / 8;

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CMD_DEPTH);

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_ERR     = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;
  localparam logic [1:0] ST_RTY_EXH = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_BUS     = 3'd1,
    S_BACKOFF = 3'd2,
`ifdef WB_CFG_READBACK_VERIFY_EN
    S_RESP    = 3'd3,
    S_VERIFY  = 3'd4
`else
    S_RESP    = 3'd3
`endif
  } state_t;

  state_t state;

  // ---------------------------------------------------------------------------
  // Command FIFO
  // ---------------------------------------------------------------------------
  logic [ADR_W-1:0] fifo_adr [CMD_DEPTH];
  logic [DAT_W-1:0] fifo_dat [CMD_DEPTH];
  logic             fifo_we  [CMD_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             rdy_en;
  logic             full;
  logic             pop;
  logic             push;

  assign full = (count == CNT_FULL);
  // The FSM consumes the head entry whenever it sits in IDLE with work queued.
  assign pop  = (state == S_IDLE) && (count != '0);
  // A full FIFO still takes a command on the edge where the head is popped.
  assign bus.cmd_ready_o = rdy_en && (!full || pop);
  assign push = bus.cmd_valid_i && bus.cmd_ready_o;

  // Pointer and occupancy bookkeeping; rdy_en keeps ready low until the first edge after reset.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      rdy_en <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (!push && pop) count <= count - CNT_W'(1);
    end
  end

  // FIFO storage; contents need no reset because occupancy is tracked separately.
  always_ff @(posedge wb_clk_i) begin
    if (push) begin
      fifo_adr[wr_ptr] <= bus.cmd_adr_i;
      fifo_dat[wr_ptr] <= bus.cmd_dat_i;
      fifo_we[wr_ptr]  <= bus.cmd_we_i;
    end
  end

  // ---------------------------------------------------------------------------
  // Bus sequencer
  // ---------------------------------------------------------------------------
  logic [TMO_W-1:0] tmo_cnt;
  logic [RTY_W-1:0] retry_cnt;
  logic             tmo_hit;

  assign tmo_hit = (tmo_cnt == TMO_LAST);

`ifdef WB_CFG_READBACK_VERIFY_EN
  logic vfy;
  logic mismatch_q;
  assign bus.rsp_mismatch_o = mismatch_q;
`else
  assign bus.rsp_mismatch_o = 1'b0;
`endif

  // Main FSM: owns every WB strobe and the response registers.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state            <= S_IDLE;
      tmo_cnt          <= '0;
      retry_cnt        <= '0;
      bus.wb_cyc_o     <= 1'b0;
      bus.wb_stb_o     <= 1'b0;
      bus.wb_we_o      <= 1'b0;
      bus.wb_adr_o     <= '0;
      bus.wb_dat_o     <= '0;
      bus.wb_sel_o     <= '0;
      bus.rsp_valid_o  <= 1'b0;
      bus.rsp_dat_o    <= '0;
      bus.rsp_status_o <= ST_OK;
`ifdef WB_CFG_READBACK_VERIFY_EN
      vfy              <= 1'b0;
      mismatch_q       <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            bus.wb_adr_o <= fifo_adr[rd_ptr];
            bus.wb_dat_o <= fifo_dat[rd_ptr];
            bus.wb_we_o  <= fifo_we[rd_ptr];
            bus.wb_cyc_o <= 1'b1;
            bus.wb_stb_o <= 1'b1;
            bus.wb_sel_o <= '1;
            tmo_cnt      <= '0;
            retry_cnt    <= '0;
            state        <= S_BUS;
          end
        end

        S_BUS: begin
          tmo_cnt <= tmo_cnt + TMO_W'(1);
          if (bus.wb_err_i || bus.wb_rty_i || bus.wb_ack_i || tmo_hit) begin
            bus.wb_cyc_o <= 1'b0;
            bus.wb_stb_o <= 1'b0;
            bus.wb_sel_o <= '0;
          end
          if (bus.wb_err_i) begin
            bus.rsp_valid_o  <= 1'b1;
            bus.rsp_status_o <= ST_ERR;
            bus.rsp_dat_o    <= '0;
            state            <= S_RESP;
          end else if (bus.wb_rty_i) begin
            if (retry_cnt != RTY_MAX) begin
              retry_cnt <= retry_cnt + RTY_W'(1);
              state     <= S_BACKOFF;
            end else begin
              bus.rsp_valid_o  <= 1'b1;
              bus.rsp_status_o <= ST_RTY_EXH;
              bus.rsp_dat_o    <= '0;
              state            <= S_RESP;
            end
          end else if (bus.wb_ack_i) begin
`ifdef WB_CFG_READBACK_VERIFY_EN
            if (bus.wb_we_o) begin
              // Acked write: read the same address back, with a fresh retry budget.
              retry_cnt <= '0;
              state     <= S_VERIFY;
            end else begin
              bus.rsp_valid_o  <= 1'b1;
              bus.rsp_status_o <= ST_OK;
              bus.rsp_dat_o    <= bus.wb_dat_i;
              mismatch_q       <= vfy && (bus.wb_dat_i != bus.wb_dat_o);
              state            <= S_RESP;
            end
`else
            bus.rsp_valid_o  <= 1'b1;
            bus.rsp_status_o <= ST_OK;
            bus.rsp_dat_o    <= bus.wb_we_o ? '0 : bus.wb_dat_i;
            state            <= S_RESP;
`endif
          end else if (tmo_hit) begin
            bus.rsp_valid_o  <= 1'b1;
            bus.rsp_status_o <= ST_TIMEOUT;
            bus.rsp_dat_o    <= '0;
            state            <= S_RESP;
          end
        end

        S_BACKOFF: begin
          // One idle cycle with cyc low, then the same command goes out again.
          bus.wb_cyc_o <= 1'b1;
          bus.wb_stb_o <= 1'b1;
          bus.wb_sel_o <= '1;
          tmo_cnt      <= '0;
          state        <= S_BUS;
        end

`ifdef WB_CFG_READBACK_VERIFY_EN
        S_VERIFY: begin
          // Gap cycle after the write, then a read of the same address.
          bus.wb_we_o  <= 1'b0;
          bus.wb_cyc_o <= 1'b1;
          bus.wb_stb_o <= 1'b1;
          bus.wb_sel_o <= '1;
          tmo_cnt      <= '0;
          vfy          <= 1'b1;
          state        <= S_BUS;
        end
`endif

        S_RESP: begin
          if (bus.rsp_ready_i) begin
            bus.rsp_valid_o <= 1'b0;
            retry_cnt       <= '0;
`ifdef WB_CFG_READBACK_VERIFY_EN
            vfy             <= 1'b0;
            mismatch_q      <= 1'b0;
`endif
            state           <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy_o    = (state != S_IDLE) || (count != '0);
  assign dbg_state = state;

endmodule

// File: tb/tb_wb_cfg_initiator.sv
// Self-checking bench for wb_cfg_initiator: directed scenarios followed by
// randomized commands against a response/termination model of the block.
module tb_wb_cfg_initiator;

  localparam int ADR_W          = 22;
  localparam int DAT_W          = 32;
  localparam int CMD_DEPTH      = 4;
  localparam int TIMEOUT_CYCLES = 255;
  localparam int MAX_RETRY      = 3;

  localparam int K_ACK    = 0;
  localparam int K_ERR    = 1;
  localparam int K_RTY    = 2;
  localparam int K_SILENT = 3;
  localparam int K_ERRACK = 4;
  localparam int K_RTYACK = 5;

  typedef struct {
    int          kind;
    int          delay;
    logic [31:0] data;
  } plan_t;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n;
  logic       busy;
  logic [2:0] dbg_state;

  always #5 clk = ~clk;

  wb_cfg_initiator_if #(.ADR_W(ADR_W), .DAT_W(DAT_W)) bus ();

  wb_cfg_initiator #(
    .ADR_W(ADR_W), .DAT_W(DAT_W), .CMD_DEPTH(CMD_DEPTH),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_n_i (rst_n),
    .bus        (bus),
    .busy_o     (busy),
    .dbg_state  (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [34:0] exp_q[$];       // {mismatch, status, data}
  plan_t plan_q[$];            // consumed by the target, one entry per bus cycle
  plan_t model_q[$];           // same plan, consumed by the model
  int start_q[$];
  int len_q[$];
  logic [ADR_W-1:0] log_adr_q[$];
  logic             log_we_q[$];
  logic [DAT_W-1:0] log_dat_q[$];
  int ncyc = 0;
  int exp_ncyc = 0;
  int tick = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic plan_t next_model();
    plan_t p;
    if (model_q.size() > 0) p = model_q.pop_front();
    else begin
      p.kind = K_ACK; p.delay = 1; p.data = 32'h0BADF00D;
    end
    return p;
  endfunction

  // Walks the termination plan attempt by attempt: err ends the command,
  // rty is retried MAX_RETRY times, silence or a too-late answer is a timeout,
  // ack finishes (or, with readback, starts the verify read).
  function automatic void model_cmd(input logic we, input logic [31:0] wd,
                                    output logic [34:0] e, output int nbus);
    plan_t p;
    int tries;
    int phase;           // 0 write, 1 plain read, 2 verify read
    bit done;
    logic [1:0]  st;
    logic [31:0] rd;
    logic        mm;
    nbus = 0; tries = 0; done = 0; st = 2'b00; rd = '0; mm = 1'b0;
    phase = we ? 0 : 1;
    while (!done) begin
      p = next_model();
      nbus++;
      if (p.kind == K_SILENT || p.delay > TIMEOUT_CYCLES) begin
        st = 2'b10; done = 1;
      end else if (p.kind == K_ERR || p.kind == K_ERRACK) begin
        st = 2'b01; done = 1;
      end else if (p.kind == K_RTY || p.kind == K_RTYACK) begin
        if (tries < MAX_RETRY) tries++;
        else begin st = 2'b11; done = 1; end
      end else if (phase == 0) begin
`ifdef WB_CFG_READBACK_VERIFY_EN
        phase = 2; tries = 0;
`else
        st = 2'b00; done = 1;
`endif
      end else begin
        rd = p.data; st = 2'b00; done = 1;
        if (phase == 2) mm = (p.data != wd);
      end
    end
    e = {mm, st, rd};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic add_plan(input int kind, input int delay, input logic [31:0] data);
    plan_t p;
    p.kind = kind; p.delay = delay; p.data = data;
    plan_q.push_back(p);
    model_q.push_back(p);
  endtask

  task automatic flush();
    plan_q.delete(); model_q.delete(); start_q.delete(); len_q.delete();
    log_adr_q.delete(); log_we_q.delete(); log_dat_q.delete();
  endtask

  task automatic do_cmd(input logic we, input logic [ADR_W-1:0] adr, input logic [DAT_W-1:0] dat);
    logic [34:0] e;
    int nb;
    int b;
    model_cmd(we, dat, e, nb);
    exp_q.push_back(e);
    exp_ncyc += nb;
    bus.cmd_valid_i = 1'b1;
    bus.cmd_we_i    = we;
    bus.cmd_adr_i   = adr;
    bus.cmd_dat_i   = dat;
    b = 0;
    while (!bus.cmd_ready_o && b < 3000) begin
      @(posedge clk); #1; b++;
    end
    chk("cmd_accept", bus.cmd_ready_o, 1);
    @(posedge clk); #1;
    bus.cmd_valid_i = 1'b0;
    bus.cmd_dat_i   = $urandom;
  endtask

  task automatic wait_rsp(input int ready_delay);
    logic [34:0] e;
    int b;
    e = '0;
    b = 0;
    while (!bus.rsp_valid_o && b < 3000) begin
      @(posedge clk); #1; b++;
    end
    chk("rsp_valid", bus.rsp_valid_o, 1);
    checks++;
    assert (exp_q.size() > 0) else begin
      errors++;
      $error("FAIL rsp_unexpected observed=response expected=none");
    end
    if (exp_q.size() > 0) e = exp_q.pop_front();
    chk("rsp_dat", bus.rsp_dat_o, e[31:0]);
    chk("rsp_status", bus.rsp_status_o, e[33:32]);
    chk("rsp_mismatch", bus.rsp_mismatch_o, e[34]);
    for (int i = 0; i < ready_delay; i++) begin
      @(posedge clk); #1;
      chk("rsp_hold_valid", bus.rsp_valid_o, 1);
      chk("rsp_hold_dat", bus.rsp_dat_o, e[31:0]);
    end
    bus.rsp_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready_i = 1'b0;
    chk("rsp_drop", bus.rsp_valid_o, 0);
  endtask

  // ---------------- target responder ----------------
  initial begin : target
    bit active;
    int n;
    plan_t cur;
    active = 0; n = 0;
    cur.kind = K_ACK; cur.delay = 1; cur.data = '0;
    bus.wb_ack_i = 1'b0; bus.wb_err_i = 1'b0; bus.wb_rty_i = 1'b0; bus.wb_dat_i = '0;
    forever begin
      @(posedge clk); #1;
      tick++;
      bus.wb_ack_i = 1'b0; bus.wb_err_i = 1'b0; bus.wb_rty_i = 1'b0; bus.wb_dat_i = '0;
      if (!rst_n) begin
        active = 0;
      end else if (bus.wb_cyc_o) begin
        if (!active) begin
          active = 1; n = 0; ncyc++;
          if (plan_q.size() > 0) cur = plan_q.pop_front();
          else begin cur.kind = K_ACK; cur.delay = 1; cur.data = 32'h0BADF00D; end
          start_q.push_back(tick);
          log_adr_q.push_back(bus.wb_adr_o);
          log_we_q.push_back(bus.wb_we_o);
          log_dat_q.push_back(bus.wb_dat_o);
        end else begin
          chk("bus_adr_stable", bus.wb_adr_o, log_adr_q[$]);
          chk("bus_we_stable", bus.wb_we_o, log_we_q[$]);
        end
        n++;
        chk("bus_stb", bus.wb_stb_o, 1);
        chk("bus_sel", bus.wb_sel_o, 4'hF);
        if (n == cur.delay) begin
          case (cur.kind)
            K_ACK:    begin bus.wb_ack_i = 1'b1; bus.wb_dat_i = cur.data; end
            K_ERR:    bus.wb_err_i = 1'b1;
            K_RTY:    bus.wb_rty_i = 1'b1;
            K_ERRACK: begin bus.wb_err_i = 1'b1; bus.wb_ack_i = 1'b1; bus.wb_dat_i = cur.data; end
            K_RTYACK: begin bus.wb_rty_i = 1'b1; bus.wb_ack_i = 1'b1; bus.wb_dat_i = cur.data; end
            default:  ;
          endcase
        end
      end else if (active) begin
        active = 0;
        len_q.push_back(n);
        chk("bus_sel_idle", bus.wb_sel_o, 0);
      end
    end
  end

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog observed=no_finish expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin : main
    logic [34:0] e;
    int b;
    bit seen;
    rst_n = 1'b0;
    bus.cmd_valid_i = 1'b0; bus.cmd_we_i = 1'b0; bus.cmd_adr_i = '0; bus.cmd_dat_i = '0;
    bus.rsp_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", bus.cmd_ready_o, 0);
    chk("rst_cyc", bus.wb_cyc_o, 0);
    chk("rst_stb", bus.wb_stb_o, 0);
    chk("rst_sel", bus.wb_sel_o, 0);
    chk("rst_adr", bus.wb_adr_o, 0);
    chk("rst_rsp_valid", bus.rsp_valid_o, 0);
    chk("rst_busy", busy, 0);
    chk("rst_state", dbg_state, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_reset", bus.cmd_ready_o, 1);

    // 1: write, ack in 2 cycles, latency check
    flush();
    add_plan(K_ACK, 2, 32'h0);
    do_cmd(1'b1, 22'h000304, 32'hDEADBEEF);
    chk("t1_cyc_edge_k", bus.wb_cyc_o, 0);
    @(posedge clk); #1;
    chk("t1_cyc_edge_k1", bus.wb_cyc_o, 1);
    wait_rsp(1);
    chk("t1_len", len_q[0], 2);
    chk("t1_we", log_we_q[0], 1);
    chk("t1_adr", log_adr_q[0], 22'h000304);
    chk("t1_dat", log_dat_q[0], 32'hDEADBEEF);
    chk("t1_ncyc", ncyc, exp_ncyc);

    // 2: read, ack after 3 cycles
    flush();
    add_plan(K_ACK, 3, 32'h12345678);
    do_cmd(1'b0, 22'h000710, 32'h0);
    wait_rsp(0);
    chk("t2_len", len_q[0], 3);
    chk("t2_we", log_we_q[0], 0);
    chk("t2_adr", log_adr_q[0], 22'h000710);
    chk("t2_ncyc", ncyc, exp_ncyc);

    // 3a: rty every time -> MAX_RETRY+1 cycles with one-cycle gaps
    flush();
    for (int i = 0; i < MAX_RETRY + 1; i++) add_plan(K_RTY, 1 + (i % 2), 32'h0);
    do_cmd(1'b0, 22'h000220, 32'h0);
    wait_rsp(0);
    chk("t3_ncyc", ncyc, exp_ncyc);
    chk("t3_cycles", len_q.size(), MAX_RETRY + 1);
    for (int i = 0; i < MAX_RETRY; i++)
      chk("t3_gap", start_q[i+1] - start_q[i] - len_q[i], 1);

    // 3b: rty twice then ack
    flush();
    add_plan(K_RTY, 1, 32'h0);
    add_plan(K_RTY, 2, 32'h0);
    add_plan(K_ACK, 1, 32'h55AA00FF);
    do_cmd(1'b0, 22'h000224, 32'h0);
    wait_rsp(0);
    chk("t3b_ncyc", ncyc, exp_ncyc);
    chk("t3b_cycles", len_q.size(), 3);

    // 4a: silent target -> timeout after exactly TIMEOUT_CYCLES
    flush();
    add_plan(K_SILENT, 1, 32'h0);
    do_cmd(1'b0, 22'h000330, 32'h0);
    wait_rsp(0);
    chk("t4_len", len_q[0], TIMEOUT_CYCLES);
    chk("t4_ncyc", ncyc, exp_ncyc);

    // 4b: ack in the last cycle before timeout wins
    flush();
    add_plan(K_ACK, TIMEOUT_CYCLES, 32'hCAFEF00D);
    do_cmd(1'b0, 22'h000334, 32'h0);
    wait_rsp(0);
    chk("t4b_len", len_q[0], TIMEOUT_CYCLES);

    // 4c: err and ack together -> err; rty and ack together -> rty
    flush();
    add_plan(K_ERRACK, 2, 32'h11112222);
    do_cmd(1'b0, 22'h000338, 32'h0);
    wait_rsp(0);
    flush();
    add_plan(K_RTYACK, 1, 32'h33334444);
    add_plan(K_ACK, 1, 32'h55556666);
    do_cmd(1'b0, 22'h00033C, 32'h0);
    wait_rsp(0);
    chk("t4c_ncyc", ncyc, exp_ncyc);

    // 5: backpressure, full FIFO, push+pop while full, ordering
    flush();
    for (int i = 0; i < 6; i++) add_plan(K_ACK, 1, 32'hA000_0000 + i);
    for (int i = 0; i < 5; i++) do_cmd(1'b0, 22'(12'h100 + 4 * i), 32'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("t5_full_ready", bus.cmd_ready_o, 0);
    chk("t5_busy", busy, 1);
    wait_rsp(0);
    chk("t5_full_pop_ready", bus.cmd_ready_o, 1);
    do_cmd(1'b0, 22'h000114, 32'h0);
    chk("t5_still_full", bus.cmd_ready_o, 0);
    for (int i = 0; i < 5; i++) wait_rsp($urandom_range(0, 2));
    chk("t5_ncyc", ncyc, exp_ncyc);
    for (int i = 0; i < 6; i++) chk("t5_order_adr", log_adr_q[i], 22'(12'h100 + 4 * i));

    // 5b: reset in the middle of a bus cycle
    flush();
    add_plan(K_SILENT, 1, 32'h0);
    do_cmd(1'b0, 22'h000120, 32'h0);
    do_cmd(1'b0, 22'h000124, 32'h0);
    b = 0;
    while (!bus.wb_cyc_o && b < 50) begin @(posedge clk); #1; b++; end
    chk("t5r_cyc_up", bus.wb_cyc_o, 1);
    repeat (10) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t5r_cyc_async", bus.wb_cyc_o, 0);
    chk("t5r_stb_async", bus.wb_stb_o, 0);
    chk("t5r_ready", bus.cmd_ready_o, 0);
    chk("t5r_busy", busy, 0);
    chk("t5r_rsp_valid", bus.rsp_valid_o, 0);
    exp_q.delete();
    exp_ncyc -= 1;   // the queued second command never reaches the bus
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("t5r_ready_release", bus.cmd_ready_o, 1);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus.wb_cyc_o || bus.rsp_valid_o) seen = 1;
    end
    chk("t5r_quiet", seen, 0);
    chk("t5r_busy_after", busy, 0);
    chk("t5r_ncyc", ncyc, exp_ncyc);

    // 6: readback verify with a one-bit mismatch
    flush();
    add_plan(K_ACK, 1, 32'h0);
    add_plan(K_ACK, 2, 32'hA5A5A5A4);
    do_cmd(1'b1, 22'h000540, 32'hA5A5A5A5);
    wait_rsp(0);
    chk("t6_ncyc", ncyc, exp_ncyc);
    chk("t6_first_we", log_we_q[0], 1);
`ifdef WB_CFG_READBACK_VERIFY_EN
    chk("t6_cycles", len_q.size(), 2);
    chk("t6_second_we", log_we_q[1], 0);
    chk("t6_second_adr", log_adr_q[1], 22'h000540);
`else
    chk("t6_cycles", len_q.size(), 1);
`endif

    // Random commands against the model
    for (int c = 0; c < 24; c++) begin
      logic we;
      logic [ADR_W-1:0] adr;
      logic [DAT_W-1:0] dat;
      int k;
      flush();
      for (int j = 0; j < 2 * (MAX_RETRY + 1); j++) begin
        k = $urandom_range(0, 15);
        if (k < 8)       add_plan(K_ACK, $urandom_range(1, 4), $urandom);
        else if (k < 10) add_plan(K_ERR, $urandom_range(1, 4), $urandom);
        else if (k < 13) add_plan(K_RTY, $urandom_range(1, 4), $urandom);
        else if (k == 13) add_plan(K_ERRACK, $urandom_range(1, 4), $urandom);
        else if (k == 14) add_plan(K_RTYACK, $urandom_range(1, 4), $urandom);
        else             add_plan(K_SILENT, 1, $urandom);
      end
      we  = 1'($urandom_range(0, 1));
      adr = 22'({$urandom_range(0, 7), 8'($urandom_range(0, 255))});
      dat = $urandom;
      do_cmd(we, adr, dat);
      wait_rsp($urandom_range(0, 3));
      chk("rnd_ncyc", ncyc, exp_ncyc);
      chk("rnd_adr", log_adr_q[0], adr);
      chk("rnd_we", log_we_q[0], we);
      if (we) chk("rnd_wdat", log_dat_q[0], dat);
    end

    chk("exp_q_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
